// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Shared constants for the 7-segment character path: character codes,
//   active-low segment patterns ({g,f,e,d,c,b,a}) used by both the encoder
//   and this decoder, word FSM state encoding, and the pattern decode helper.
package seg7_pkg;

  // Character codes carried on char_code
  localparam logic [2:0] CHAR_H = 3'd0;
  localparam logic [2:0] CHAR_E = 3'd1;
  localparam logic [2:0] CHAR_L = 3'd2;
  localparam logic [2:0] CHAR_O = 3'd3;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_H     = 7'b0001001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_O     = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Word FSM: state index equals the number of HELLO characters matched
  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } word_state_t;

  // Result of looking a pattern up in the character table
  typedef struct packed {
    logic       hit;
    logic [2:0] code;
  } decode_t;

  // Table lookup; blank and unknown patterns both report hit=0
  function automatic decode_t seg_decode(input logic [6:0] pat);
    decode_t d;
    d.hit  = 1'b1;
    d.code = CHAR_H;
    case (pat)
      SEG_H: d.code = CHAR_H;
      SEG_E: d.code = CHAR_E;
      SEG_L: d.code = CHAR_L;
      SEG_O: d.code = CHAR_O;
      default: begin
        d.hit  = 1'b0;
        d.code = CHAR_H;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg7_stable_filter.sv
// seg7_stable_filter
//   Brings the asynchronous segment bus into the clk domain through a 2-flop
//   synchroniser and accepts a pattern once it has been held steady long
//   enough. accept is a registered one-cycle strobe; pattern carries the
//   accepted value in the same cycle.
// Ports
//   clk      in   1  system clock, rising edge
//   rst      in   1  asynchronous, active-high reset
//   seg_n    in   7  raw active-low segment bus
//   pattern  out  7  pattern being accepted (valid while accept is high)
//   accept   out  1  one-cycle strobe, stability counter just reached STABLE_CYCLES-1
module seg7_stable_filter
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_n,
  output logic [6:0] pattern,
  output logic       accept
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  // accept is registered, so it is raised on the edge that moves the
  // counter from STABLE_CYCLES-2 to STABLE_CYCLES-1
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [6:0]       sync1_r;
  logic [6:0]       seg_s_r;
  logic [6:0]       prev_r;
  logic [CNT_W-1:0] cnt_r;
  logic             same_s;

  assign same_s = (seg_s_r == prev_r);

  // Synchroniser chain plus one-cycle-delayed copy used for change detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= SEG_BLANK;
      seg_s_r <= SEG_BLANK;
      prev_r  <= SEG_BLANK;
    end else begin
      sync1_r <= seg_n;
      seg_s_r <= sync1_r;
      prev_r  <= seg_s_r;
    end
  end

  // Stability counter: clears on any change, saturates at STABLE_CYCLES
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (!same_s) begin
      cnt_r <= '0;
    end else if (cnt_r != CNT_MAX) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Accept strobe and the pattern it refers to
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accept  <= 1'b0;
      pattern <= SEG_BLANK;
    end else if (same_s && (cnt_r == CNT_PRE)) begin
      accept  <= 1'b1;
      pattern <= seg_s_r;
    end else begin
      accept  <= 1'b0;
      pattern <= pattern;
    end
  end

endmodule

// File: rtl/seg7_pattern_decoder.sv
// seg7_pattern_decoder
//   Recovers H/E/L/O character codes from an active-low 7-segment bus and
//   detects the word HELLO in the resulting character stream.
//   A character is reported once per new stable pattern; a blank pattern acts
//   as a separator so that a repeated character (L, blank, L) is reported twice.
// Ports
//   clk         in   1  system clock, rising edge
//   rst         in   1  asynchronous, active-high reset
//   seg_n       in   7  segment pattern {g,f,e,d,c,b,a}, active-low, asynchronous
//   char_code   out  3  last decoded character: 000=H 001=E 010=L 011=O
//   char_valid  out  1  one-cycle pulse, char_code updated this cycle
//   char_err    out  1  one-cycle pulse, stable pattern not in the table
//   word_hit    out  1  one-cycle pulse, HELLO completed
//   word_pos    out  3  HELLO characters matched so far (0..4)
module seg7_pattern_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_n,
  output logic [2:0] char_code,
  output logic       char_valid,
  output logic       char_err,
  output logic       word_hit,
  output logic [2:0] word_pos
);

  logic [6:0]  acc_pattern_s;
  logic        acc_s;
  decode_t     dec_s;

  logic [6:0]  last_r;
  logic [6:0]  last_next_s;
  logic        valid_next_s;
  logic        err_next_s;
  logic [2:0]  code_next_s;

  word_state_t state_r;
  word_state_t state_next_s;
  logic        hit_next_s;

  seg7_stable_filter #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_filter (
    .clk     (clk),
    .rst     (rst),
    .seg_n   (seg_n),
    .pattern (acc_pattern_s),
    .accept  (acc_s)
  );

  assign dec_s = seg_decode(acc_pattern_s);

  // Character emit decision: only a newly accepted pattern that differs from the last one counts
  always_comb begin
    last_next_s  = last_r;
    valid_next_s = 1'b0;
    err_next_s   = 1'b0;
    code_next_s  = char_code;
    if (acc_s && (acc_pattern_s != last_r)) begin
      last_next_s = acc_pattern_s;
      if (dec_s.hit) begin
        valid_next_s = 1'b1;
        code_next_s  = dec_s.code;
      end else if (acc_pattern_s == SEG_BLANK) begin
        // blank only re-arms the repeat check
        valid_next_s = 1'b0;
      end else begin
        err_next_s = 1'b1;
      end
    end else begin
      last_next_s = last_r;
    end
  end

  // Character output registers and last-accepted pattern
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_r     <= SEG_BLANK;
      char_code  <= CHAR_H;
      char_valid <= 1'b0;
      char_err   <= 1'b0;
    end else begin
      last_r     <= last_next_s;
      char_code  <= code_next_s;
      char_valid <= valid_next_s;
      char_err   <= err_next_s;
    end
  end

  // Word FSM next state; reacts to the registered character pulses
  always_comb begin
    state_next_s = state_r;
    hit_next_s   = 1'b0;
    if (char_err) begin
      state_next_s = S0;
    end else if (char_valid) begin
      if (char_code == CHAR_H) begin
        // an H always restarts the word, since H only appears first in HELLO
        state_next_s = S1;
      end else begin
        case (state_r)
          S1:      state_next_s = (char_code == CHAR_E) ? S2 : S0;
          S2:      state_next_s = (char_code == CHAR_L) ? S3 : S0;
          S3:      state_next_s = (char_code == CHAR_L) ? S4 : S0;
          S4: begin
            state_next_s = S0;
            hit_next_s   = (char_code == CHAR_O);
          end
          default: state_next_s = S0;
        endcase
      end
    end else begin
      state_next_s = state_r;
    end
  end

  // Word FSM state and its registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= S0;
      word_pos <= 3'd0;
      word_hit <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      word_pos <= state_next_s;
      word_hit <= hit_next_s;
    end
  end

endmodule

// File: tb/tb_seg7_pattern_decoder.sv
// tb_seg7_pattern_decoder
//   Directed sequences followed by random segment-bus traffic. Every cycle the
//   outputs are compared with a reference model built from run lengths of the
//   sampled bus and a suffix match of the character stream against HELLO.
module tb_seg7_pattern_decoder;

  localparam int STABLE_CYCLES = 4;
  localparam logic [6:0] P_H     = 7'b0001001;
  localparam logic [6:0] P_E     = 7'b0000110;
  localparam logic [6:0] P_L     = 7'b1000111;
  localparam logic [6:0] P_O     = 7'b1000000;
  localparam logic [6:0] P_BLANK = 7'b1111111;
  localparam logic [6:0] P_ZERO  = 7'b0000000;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg_n;
  logic [2:0] char_code;
  logic       char_valid;
  logic       char_err;
  logic       word_hit;
  logic [2:0] word_pos;

  always #5 clk = ~clk;

  seg7_pattern_decoder #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_n      (seg_n),
    .char_code  (char_code),
    .char_valid (char_valid),
    .char_err   (char_err),
    .word_hit   (word_hit),
    .word_pos   (word_pos)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int hits_seen = 0;
  int step_no   = 0;
  int first_valid_step = -1;

  // reference model state
  logic [6:0] hist[$];
  logic [6:0] m_last;
  int         m_code;
  bit         m_valid, m_err, m_hit;
  int         m_pos;
  int         word_q[$];
  int         hello_codes[5] = '{0, 1, 2, 2, 3};

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic int char_of(input logic [6:0] p);
    if (p == P_H) return 0;
    if (p == P_E) return 1;
    if (p == P_L) return 2;
    if (p == P_O) return 3;
    if (p == P_BLANK) return -2;
    return -1;
  endfunction

  function automatic bit suffix_is_prefix(input int k);
    int n = word_q.size();
    if (n < k) return 1'b0;
    for (int i = 0; i < k; i++)
      if (word_q[n - k + i] != hello_codes[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    hist.delete();
    repeat (STABLE_CYCLES + 2) hist.push_back(P_BLANK);
    m_last = P_BLANK;
    m_code = 0; m_valid = 0; m_err = 0; m_hit = 0; m_pos = 0;
    word_q.delete();
  endtask

  // one clock edge of the model, given the bus value sampled at that edge
  task automatic model_edge(input logic [6:0] s);
    int idx, len, c;
    logic [6:0] v;
    // word layer consumes the character pulse of the previous cycle
    m_hit = 0;
    if (m_err) begin
      word_q.delete();
      m_pos = 0;
    end else if (m_valid) begin
      word_q.push_back(m_code);
      if (word_q.size() > 5) void'(word_q.pop_front());
      if (suffix_is_prefix(5)) begin
        m_hit = 1;
        word_q.delete();
      end
      m_pos = 0;
      for (int k = 4; k >= 1; k--)
        if (m_pos == 0 && suffix_is_prefix(k)) m_pos = k;
    end
    // character layer: a value sampled three edges ago whose run is exactly
    // STABLE_CYCLES long is the one accepted now
    hist.push_back(s);
    if (hist.size() > 24) void'(hist.pop_front());
    m_valid = 0;
    m_err   = 0;
    idx = hist.size() - 4;
    v = hist[idx];
    len = 0;
    for (int j = idx; j >= 0; j--) begin
      if (hist[j] != v) break;
      len++;
    end
    if (len == STABLE_CYCLES && v != m_last) begin
      m_last = v;
      c = char_of(v);
      if (c >= 0) begin
        m_valid = 1;
        m_code  = c;
      end else if (c == -1) begin
        m_err = 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(seg_n);
    step_no++;
    @(negedge clk);
    check_val("char_valid", 8'(char_valid), 8'(m_valid));
    check_val("char_err",   8'(char_err),   8'(m_err));
    check_val("char_code",  8'(char_code),  8'(m_code));
    check_val("word_hit",   8'(word_hit),   8'(m_hit));
    check_val("word_pos",   8'(word_pos),   8'(m_pos));
    if (word_hit) hits_seen++;
    if (char_valid && first_valid_step < 0) first_valid_step = step_no;
  endtask

  task automatic hold(input logic [6:0] p, input int n);
    seg_n = p;
    repeat (n) step();
  endtask

  // assert reset between edges and check that outputs clear without a clock
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_val("rst_valid", 8'(char_valid), 8'd0);
    check_val("rst_err",   8'(char_err),   8'd0);
    check_val("rst_code",  8'(char_code),  8'd0);
    check_val("rst_hit",   8'(word_hit),   8'd0);
    check_val("rst_pos",   8'(word_pos),   8'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step_no = 0;
    first_valid_step = -1;
  endtask

  function automatic logic [6:0] rand_pattern();
    case ($urandom_range(0, 9))
      0, 1:    return P_H;
      2:       return P_E;
      3, 4:    return P_L;
      5:       return P_O;
      6, 7:    return P_BLANK;
      default: return 7'($urandom_range(0, 127));
    endcase
  endfunction

  initial begin
    int h0;
    seg_n = P_BLANK;
    rst   = 1'b1;
    @(negedge clk);
    do_reset();

    // 1: single H, exact latency, no repeat while held
    hold(P_H, 20);
    check_val("t1_latency", 8'(first_valid_step), 8'(STABLE_CYCLES + 3));

    // 2: HELLO with a blank separating the two Ls
    h0 = hits_seen;
    hold(P_H, 10); hold(P_E, 10); hold(P_L, 10);
    hold(P_BLANK, 10); hold(P_L, 10); hold(P_O, 10);
    check_val("t2_hits", 8'(hits_seen - h0), 8'd1);
    hold(P_BLANK, 10);

    // 3: HELO gives no word hit
    h0 = hits_seen;
    hold(P_H, 10); hold(P_E, 10); hold(P_L, 10); hold(P_O, 10);
    check_val("t3_hits", 8'(hits_seen - h0), 8'd0);

    // 4: short glitch inside L, then an invalid pattern held
    hold(P_L, 10); hold(P_ZERO, 2); hold(P_L, 8);
    hold(P_ZERO, 10);
    check_val("t4_code_kept", 8'(char_code), 8'd2);

    // 5: reset in S3 with O mid-count, then O re-accepted
    hold(P_BLANK, 10); hold(P_H, 10); hold(P_E, 10); hold(P_L, 10);
    check_val("t5_pos_s3", 8'(word_pos), 8'd3);
    hold(P_O, 3);
    do_reset();
    hold(P_O, 12);
    check_val("t5_reemit", 8'(first_valid_step), 8'(STABLE_CYCLES + 3));

    // 6: H,H,E without blank
    hold(P_BLANK, 10); hold(P_H, 10); hold(P_H, 10); hold(P_E, 10);
    check_val("t6_pos", 8'(word_pos), 8'd2);

    // random traffic, with occasional full words and rare resets
    for (int seg = 0; seg < 300; seg++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 7) == 0) begin
        hold(P_H, $urandom_range(4, 9)); hold(P_E, $urandom_range(4, 9));
        hold(P_L, $urandom_range(4, 9)); hold(P_BLANK, $urandom_range(4, 9));
        hold(P_L, $urandom_range(4, 9)); hold(P_O, $urandom_range(4, 9));
      end else begin
        hold(rand_pattern(), $urandom_range(1, 12));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
